pcie_multilane_scrambler: RTL and testbench

//  Multi-lane PCIe PHY TX scrambler.
//  - One independent LFSR per lane.
//  - Runtime-selectable mode: Gen1/2 (8b/10b, 16-bit LFSR) or Gen3 (128b/130b, 23-bit LFSR with per-lane seeds).
//  - Sits between the TX framing/ordered-set mux and the lane encoders.
//  - Valid/ready pipelined with one register stage.

---
 rtl/pcie_scr_pkg.sv | 39 +++
 rtl/pcie_lane_lfsr.sv | 55 +++++
 rtl/pcie_multilane_scrambler.sv | 95 +++++++++
 tb/tb_pcie_multilane_scrambler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pcie_scr_pkg.sv
// Shared types, polynomials, seeds and the byte-wide LFSR step for the multi-lane PCIe TX scrambler.
package pcie_scr_pkg;

  typedef enum logic {SCR_GEN12 = 1'b0, SCR_GEN3 = 1'b1} scr_mode_e;

  // Galois feedback masks: the polynomial terms below the top degree.
  localparam logic [22:0] GEN1_POLY = 23'h000039;
  localparam logic [22:0] GEN3_POLY = 23'h210125;
  localparam logic [22:0] GEN1_SEED = 23'h00FFFF;
  localparam logic [22:0] GEN3_SEED [8] = '{
    23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
    23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807
  };

  function automatic logic [22:0] lane_seed(input scr_mode_e mode, input logic [3:0] lane);
    return (mode == SCR_GEN3) ? GEN3_SEED[lane[2:0]] : GEN1_SEED;
  endfunction

  // Returns {next_state, keystream_byte}; keystream bit 0 is the first tap out.
  function automatic logic [30:0] lfsr_step_byte(input logic [22:0] state, input scr_mode_e mode,
                                                  input logic advance);
    logic [22:0] s;
    logic [7:0]  ks;
    s  = state;
    ks = '0;
    for (int b = 0; b < 8; b++) begin
      if (mode == SCR_GEN3) begin
        ks[b] = s[22];
        s     = {s[21:0], 1'b0} ^ (s[22] ? GEN3_POLY : 23'h0);
      end else begin
        ks[b] = s[15];
        s     = {7'd0, s[14:0], 1'b0} ^ (s[15] ? GEN1_POLY : 23'h0);
      end
    end
    if (!advance) s = state;
    return {s, ks};
  endfunction

endpackage

// File: rtl/pcie_lane_lfsr.sv
// One lane's scrambler: unrolls SYMS byte steps combinationally, commits LFSR state only on accept.
module pcie_lane_lfsr
  import pcie_scr_pkg::*;
#(
  parameter int LANE_WIDTH = 16,
  parameter int LANE_IDX   = 0,
  localparam int SYMS      = LANE_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  scr_mode_e             mode_i,
  input  logic                  reseed_i,
  input  logic                  accept_i,
  input  logic                  init_i,
  input  logic                  bypass_i,
  input  logic [LANE_WIDTH-1:0] data_i,
  input  logic [SYMS-1:0]       k_i,
  input  logic [SYMS-1:0]       hold_i,
  output logic [LANE_WIDTH-1:0] data_o
);

  localparam logic [3:0] LANE_ID = 4'(LANE_IDX);

  logic [22:0] state_q, state_d;
  logic [22:0] seed, st;
  logic [30:0] r;
  logic [7:0]  byte_in;

  always_comb begin
    seed    = lane_seed(mode_i, LANE_ID);
    st      = (reseed_i || init_i) ? seed : state_q;
    data_o  = '0;
    r       = '0;
    byte_in = '0;
    for (int s = 0; s < SYMS; s++) begin
      byte_in = data_i[s*8 +: 8];
      r       = lfsr_step_byte(st, mode_i, !hold_i[s]);
      // K symbols only bypass in Gen1/2; Gen3 scrambles them like data.
      if (hold_i[s] || bypass_i || (k_i[s] && mode_i == SCR_GEN12))
        data_o[s*8 +: 8] = byte_in;
      else
        data_o[s*8 +: 8] = byte_in ^ r[7:0];
      st = r[30:8];
    end
    if (accept_i)      state_d = st;
    else if (reseed_i) state_d = seed;
    else               state_d = state_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= lane_seed(mode_i, LANE_ID);
    else          state_q <= state_d;
  end

endmodule

// File: rtl/pcie_multilane_scrambler.sv
// Multi-lane PCIe TX scrambler, Gen1/2 or Gen3, one valid/ready register stage (1-cycle latency, holds on stall).
// Optional PCIE_SCR_BYPASS_EN adds scr_bypass: data passes through while the LFSRs keep advancing.
module pcie_multilane_scrambler
  import pcie_scr_pkg::*;
#(
  parameter int NUM_LANES  = 8,
  parameter int LANE_WIDTH = 16,
  parameter int DATA_WIDTH = NUM_LANES * LANE_WIDTH,
  localparam int SYMS      = LANE_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mode_gen3,
`ifdef PCIE_SCR_BYPASS_EN
  input  logic                      scr_bypass,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [NUM_LANES*SYMS-1:0] in_k,
  input  logic [NUM_LANES*SYMS-1:0] in_hold,
  input  logic [NUM_LANES-1:0]      in_init,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [NUM_LANES*SYMS-1:0] out_k
);

  scr_mode_e                 mode_q, mode_in;
  logic                      mode_chg, accept, bypass;
  logic [DATA_WIDTH-1:0]     scr_data;
  logic                      out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
  logic [NUM_LANES*SYMS-1:0] out_k_q, out_k_d;

`ifdef PCIE_SCR_BYPASS_EN
  assign bypass = scr_bypass;
`else
  assign bypass = 1'b0;
`endif

  // The live mode input drives the lanes so a beat on a mode-change edge uses the new mode's seeds.
  assign mode_in  = scr_mode_e'(mode_gen3);
  assign mode_chg = (mode_in != mode_q);
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    pcie_lane_lfsr #(.LANE_WIDTH(LANE_WIDTH), .LANE_IDX(l)) u_lane (
      .clk_i    (clk),
      .rst_n_i  (reset_n),
      .mode_i   (mode_in),
      .reseed_i (mode_chg),
      .accept_i (accept),
      .init_i   (in_init[l]),
      .bypass_i (bypass),
      .data_i   (in_data[l*LANE_WIDTH +: LANE_WIDTH]),
      .k_i      (in_k[l*SYMS +: SYMS]),
      .hold_i   (in_hold[l*SYMS +: SYMS]),
      .data_o   (scr_data[l*LANE_WIDTH +: LANE_WIDTH])
    );
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_k_d     = out_k_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = scr_data;
      out_k_d     = in_k;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_k_q     <= '0;
      mode_q      <= mode_in;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_k_q     <= out_k_d;
      mode_q      <= mode_in;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_k     = out_k_q;

endmodule

// File: tb/tb_pcie_multilane_scrambler.sv
// Randomized bench for pcie_multilane_scrambler with a behavioural keystream model and directed golden vectors.
module tb_pcie_multilane_scrambler;

  localparam int NL = 8;
  localparam int LW = 16;
  localparam int NS = LW / 8;
  localparam int DW = NL * LW;

  logic          clk = 1'b0;
  logic          reset_n, mode_gen3, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [DW-1:0] in_data, out_data;
  logic [NL*NS-1:0] in_k, in_hold, out_k;
  logic [NL-1:0] in_init;

  pcie_multilane_scrambler #(.NUM_LANES(NL), .LANE_WIDTH(LW)) dut (
    .clk(clk), .reset_n(reset_n), .mode_gen3(mode_gen3),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_k(in_k), .in_hold(in_hold), .in_init(in_init),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_k(out_k)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: bit-serial Galois LFSR per lane, taken from the polynomial definitions.
  int unsigned seeds3 [8] = '{'h1DBFBC, 'h0607BB, 'h1EC760, 'h18C0DB,
                              'h010F12, 'h19CFC9, 'h0277CE, 'h1BB807};
  int unsigned mst [NL];
  bit          mmode;
  logic [DW-1:0]    exp_d [$];
  logic [NL*NS-1:0] exp_k [$];
  logic [DW-1:0]    got_q [$];
  bit            stall_pend = 0, rst_prev = 0;
  logic [DW-1:0] held_d;
  logic [NL*NS-1:0] held_k;

  function automatic int unsigned seed_of(bit g3, int lane);
    return g3 ? seeds3[lane % 8] : 32'hFFFF;
  endfunction

  function automatic logic [DW-1:0] model_beat(bit g3);
    logic [DW-1:0] e;
    int unsigned st, tap;
    logic [7:0] b, ks;
    e = '0;
    for (int l = 0; l < NL; l++) begin
      st = in_init[l] ? seed_of(g3, l) : mst[l];
      for (int s = 0; s < NS; s++) begin
        b = in_data[l*LW + s*8 +: 8];
        if (in_hold[l*NS+s]) begin
          e[l*LW + s*8 +: 8] = b;
        end else begin
          ks = 0;
          for (int i = 0; i < 8; i++) begin
            tap   = g3 ? (st >> 22) & 1 : (st >> 15) & 1;
            ks[i] = tap[0];
            if (g3) st = ((st << 1) ^ (tap != 0 ? 32'h210125 : 0)) & 32'h7FFFFF;
            else    st = ((st << 1) ^ (tap != 0 ? 32'h39 : 0)) & 32'hFFFF;
          end
          e[l*LW + s*8 +: 8] = (in_k[l*NS+s] && !g3) ? b : (b ^ ks);
        end
      end
      mst[l] = st;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_prev) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_k", out_k, 0);
    end
    if (stall_pend) begin
      chk("stall_data", out_data, held_d);
      chk("stall_k", out_k, held_k);
    end
    if (reset_n) chk("in_ready", in_ready, !out_valid || out_ready);
    if (reset_n && out_valid && out_ready) begin
      chk("exp_avail", exp_d.size() != 0, 1'b1);
      if (exp_d.size() != 0) begin
        chk("out_data", out_data, exp_d.pop_front());
        chk("out_k", out_k, exp_k.pop_front());
      end
      got_q.push_back(out_data);
    end
    if (!reset_n) begin
      exp_d.delete();
      exp_k.delete();
      mmode = mode_gen3;
      for (int l = 0; l < NL; l++) mst[l] = seed_of(mmode, l);
    end else begin
      if (mode_gen3 != mmode) begin
        mmode = mode_gen3;
        for (int l = 0; l < NL; l++) mst[l] = seed_of(mmode, l);
      end
      if (in_valid && in_ready) begin
        exp_d.push_back(model_beat(mmode));
        exp_k.push_back(in_k);
      end
    end
    stall_pend = reset_n && out_valid && !out_ready;
    held_d     = out_data;
    held_k     = out_k;
    rst_prev   = !reset_n;
  end

  task automatic send(input logic [DW-1:0] d, input logic [NL*NS-1:0] k,
                      input logic [NL*NS-1:0] h, input logic [NL-1:0] init);
    in_valid = 1'b1; in_data = d; in_k = k; in_hold = h; in_init = init;
    @(posedge clk); #1;
    in_valid = 1'b0; in_init = '0; in_k = '0; in_hold = '0;
  endtask

  task automatic wait_got(input int n, input string tag);
    int cyc;
    cyc = 0;
    while (got_q.size() < n && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk(tag, got_q.size(), n);
  endtask

  logic [7:0] golden [8] = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82};

  initial begin
    reset_n = 1'b0; mode_gen3 = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_k = '0; in_hold = '0; in_init = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Gen1 zero-data keystream on lane 0
    got_q.delete();
    send('0, '0, '0, '1);
    for (int i = 1; i < 4; i++) send('0, '0, '0, '0);
    wait_got(4, "t1_cnt");
    if (got_q.size() >= 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("t1_beat%0d", i), got_q[i][15:0], {golden[2*i+1], golden[2*i]});

    // K symbol passes through but advances the LFSR
    got_q.delete();
    send({{(DW-16){1'b0}}, 16'h00BC}, 16'h0001, '0, '1);
    wait_got(1, "t2_cnt");
    if (got_q.size() >= 1) chk("t2_k", got_q[0][15:0], 16'h17BC);

    // SKP holds do not consume keystream
    got_q.delete();
    send({{(DW-16){1'b0}}, 16'h1C00}, '0, 16'h0002, '1);
    send({{(DW-16){1'b0}}, 16'h1C1C}, '0, 16'h0003, '0);
    send('0, '0, '0, '0);
    wait_got(3, "t3_cnt");
    if (got_q.size() >= 3) begin
      chk("t3_b0", got_q[0][15:0], 16'h1CFF);
      chk("t3_b1", got_q[1][15:0], 16'h1C1C);
      chk("t3_b2", got_q[2][15:0], 16'hC017);
    end

    // Gen3 all-lane reseed, zero data (model-checked per lane)
    mode_gen3 = 1'b1;
    @(posedge clk); #1;
    send('0, '0, '0, '1);
    for (int i = 0; i < 3; i++) send('0, '0, '0, '0);

    // Backpressure for 5 cycles with a pending beat
    send({$urandom, $urandom, $urandom, $urandom}, '0, '0, '0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) send({$urandom, $urandom, $urandom, $urandom}, '0, '0, '0);

    // Randomized traffic with mode toggles and mid-stream resets
    for (int c = 0; c < 1500; c++) begin
      reset_n   = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 39) == 0) mode_gen3 = ~mode_gen3;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < NL*NS; i++) begin
        in_k[i]    = ($urandom_range(0, 7) == 0);
        in_hold[i] = ($urandom_range(0, 9) == 0);
      end
      for (int l = 0; l < NL; l++) in_init[l] = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end

    reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_init = '0;
    repeat (4) @(posedge clk);
    #1 chk("drain", exp_d.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
